// File: rtl/period_meter_if.sv
// Signal bundle for period_meter: the slow input plus the measurement results.
// PERIOD_METER_FULL_EN adds the full-period sum and its valid pulse.
interface period_meter_if #(
    parameter int CNT_W = 14
);
    logic             sig_in;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             in_range;
    logic             locked;
    logic             timeout;
`ifdef PERIOD_METER_FULL_EN
    logic [CNT_W:0]   full_period;
    logic             full_valid;
`endif

`ifdef PERIOD_METER_FULL_EN
    modport master (input sig_in,
                    output half_period, period_valid, in_range, locked, timeout,
                    output full_period, full_valid);
    modport slave  (output sig_in,
                    input half_period, period_valid, in_range, locked, timeout,
                    input full_period, full_valid);
`else
    modport master (input sig_in,
                    output half_period, period_valid, in_range, locked, timeout);
    modport slave  (output sig_in,
                    input half_period, period_valid, in_range, locked, timeout);
`endif
endinterface

// File: rtl/period_meter.sv
// Half-period meter for a slow square wave on the 4 kHz domain, with lock and timeout.
// Optional feature macro PERIOD_METER_FULL_EN adds the sum of the last two half-periods.
module period_meter #(
    parameter int CNT_W       = 14,
    parameter int NOM_HALF    = 2000,
    parameter int TOL         = 20,
    parameter int LOCK_N      = 2,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic             clk_4kHz,
    input  logic             rst,
    period_meter_if.master   bus
);
    localparam int             LC_W      = $clog2(LOCK_N + 1);
    localparam logic [CNT_W:0] RANGE_LO  = (CNT_W + 1)'(NOM_HALF - TOL);
    localparam logic [CNT_W:0] RANGE_HI  = (CNT_W + 1)'(NOM_HALF + TOL);
    localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W + 1)'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {IDLE, MEASURE} state_e;

    state_e            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  half_q, half_d;
    logic              pv_q, pv_d;
    logic              rng_q, rng_d;
    logic              lock_q, lock_d;
    logic              to_q, to_d;
    logic [LC_W-1:0]   lc_q, lc_d;

    logic              sig_edge;
    logic [CNT_W:0]    meas;
    logic              meas_ok;
    logic [LC_W-1:0]   lc_inc;

`ifdef PERIOD_METER_FULL_EN
    logic [CNT_W-1:0]  prev_q, prev_d;
    logic              have_q, have_d;
    logic [CNT_W:0]    fp_q, fp_d;
    logic              fv_q, fv_d;
`endif

    // The fixed synchronizer latency is identical for every edge, so it cancels out.
    assign sig_edge = s2_q ^ s3_q;
    assign meas     = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign meas_ok  = (meas >= RANGE_LO) && (meas <= RANGE_HI);
    assign lc_inc   = (lc_q == LC_W'(LOCK_N)) ? lc_q : lc_q + LC_W'(1);

    // NOTE: every flop uses <= so all registers sample pre-edge values together.
    always_ff @(posedge clk_4kHz or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            pv_q    <= 1'b0;
            rng_q   <= 1'b0;
            lock_q  <= 1'b0;
            to_q    <= 1'b0;
            lc_q    <= '0;
`ifdef PERIOD_METER_FULL_EN
            prev_q  <= '0;
            have_q  <= 1'b0;
            fp_q    <= '0;
            fv_q    <= 1'b0;
`endif
        end else begin
            s1_q    <= bus.sig_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            pv_q    <= pv_d;
            rng_q   <= rng_d;
            lock_q  <= lock_d;
            to_q    <= to_d;
            lc_q    <= lc_d;
`ifdef PERIOD_METER_FULL_EN
            prev_q  <= prev_d;
            have_q  <= have_d;
            fp_q    <= fp_d;
            fv_q    <= fv_d;
`endif
        end
    end

    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        pv_d    = 1'b0;
        rng_d   = rng_q;
        lock_d  = lock_q;
        to_d    = to_q;
        lc_d    = lc_q;
`ifdef PERIOD_METER_FULL_EN
        prev_d  = prev_q;
        have_d  = have_q;
        fp_d    = fp_q;
        fv_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sig_edge) begin
                    state_d = MEASURE;
                    to_d    = 1'b0;
                end
            end
            MEASURE: begin
                if (sig_edge) begin
                    half_d = meas[CNT_W-1:0];
                    pv_d   = 1'b1;
                    rng_d  = meas_ok;
                    cnt_d  = '0;
                    if (meas_ok) begin
                        lc_d   = lc_inc;
                        lock_d = (lc_inc == LC_W'(LOCK_N));
                    end else begin
                        lc_d   = '0;
                        lock_d = 1'b0;
                    end
`ifdef PERIOD_METER_FULL_EN
                    fp_d   = {1'b0, prev_q} + {1'b0, meas[CNT_W-1:0]};
                    fv_d   = have_q;
                    prev_d = meas[CNT_W-1:0];
                    have_d = 1'b1;
`endif
                end else if (meas == TIMEOUT_V) begin
                    to_d    = 1'b1;
                    lock_d  = 1'b0;
                    lc_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef PERIOD_METER_FULL_EN
                    have_d  = 1'b0;
`endif
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : meas[CNT_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.half_period  = half_q;
    assign bus.period_valid = pv_q;
    assign bus.in_range     = rng_q;
    assign bus.locked       = lock_q;
    assign bus.timeout      = to_q;
`ifdef PERIOD_METER_FULL_EN
    assign bus.full_period  = fp_q;
    assign bus.full_valid   = fv_q;
`endif
endmodule
